// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - command codes, FSM states and address layout for the SDRAM controller emulator
package sdram_pkg;

  localparam int SDRC_ADDR_W       = 21;
  localparam int BANK_W            = 2;
  localparam int ROW_W             = 11;
  localparam int COL_W             = 8;
  localparam int BANK_LSB          = 19;
  localparam int ROW_LSB           = 8;
  localparam int COL_LSB           = 0;
  localparam int NUM_BANKS         = 4;
  localparam int PRECHARGE_ALL_BIT = 10;
  localparam int SDRAM_BURST_MAX   = 256;

  typedef enum logic [2:0] {
    CMD_LOAD_MODE = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVATE  = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_NOP       = 3'b111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_READ,
    ST_BUSY
  } sdrc_state_e;

  function automatic logic [SDRC_ADDR_W-1:0] sdrc_flat_addr(
    input logic [BANK_W-1:0] bank,
    input logic [ROW_W-1:0]  row,
    input logic [COL_W-1:0]  col
  );
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/sdram_emulator_ram.sv
// rtl/sdram_emulator_ram.sv - single-port 32-bit block RAM, byte write enables, registered read
module sdram_emulator_ram #(
  parameter int DepthBits = 15
) (
  input  logic                 clk,
  input  logic [3:0]           we_i,
  input  logic [DepthBits-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**DepthBits];
  logic [31:0] rdata_q;

  // No reset: contents must survive a controller reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_controller_emulator.sv
// rtl/sdram_controller_emulator.sv - block-RAM stand-in for the SDRAM controller user interface
// Optional protocol checker built when SDRC_EMULATOR_CHECK_EN is defined.
module sdram_controller_emulator
  import sdram_pkg::*;
#(
  parameter int DepthBits     = 15,
  parameter int InitCycles    = 200,
  parameter int ReadLatency   = 4,
  parameter int CommandCycles = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   I_sdrc_cmd_en,
  input  logic [2:0]             I_sdrc_cmd,
  input  logic                   I_sdrc_precharge_ctrl,
  input  logic                   I_sdram_power_down,
  input  logic                   I_sdram_selfrefresh,
  input  logic [SDRC_ADDR_W-1:0] I_sdrc_addr,
  input  logic [3:0]             I_sdrc_dqm,
  input  logic [31:0]            I_sdrc_data,
  input  logic [7:0]             I_sdrc_data_len,
  output logic [31:0]            O_sdrc_data,
  output logic                   O_sdrc_init_done,
  output logic                   O_sdrc_cmd_ack,
  output logic                   protocol_error
);

  localparam int BurstSpan = ReadLatency + SDRAM_BURST_MAX + CommandCycles;
  localparam int CntLimit  = (InitCycles > BurstSpan) ? InitCycles : BurstSpan;
  localparam int CntW      = $clog2(CntLimit + 1);

  if (ReadLatency < 2) begin : g_bad_read_latency
    $error("sdram_controller_emulator: ReadLatency must be at least 2");
  end

  sdrc_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [7:0]           len_q, len_d;
  logic                 autopre_q, autopre_d;
  logic                 ack_q, ack_d;
  logic                 rd_v_q, rd_v_d;
  logic [31:0]          data_q, data_d;
  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [ROW_W-1:0]     open_row_q [NUM_BANKS];
  logic [ROW_W-1:0]     open_row_d [NUM_BANKS];

  sdram_cmd_e           cmd;
  logic                 sample;
  logic [BANK_W-1:0]    bank_in;
  logic [ROW_W-1:0]     row_in;
  logic [COL_W-1:0]     col_in;

  logic [3:0]             ram_we;
  logic [SDRC_ADDR_W-1:0] flat_addr;
  logic [DepthBits-1:0]   ram_addr;
  logic [31:0]            ram_rdata;
  logic                   rd_issue;
  logic [CntW-1:0]        rd_idx;

  assign cmd     = sdram_cmd_e'(I_sdrc_cmd);
  assign sample  = (state_q == ST_IDLE) && I_sdrc_cmd_en;
  assign bank_in = I_sdrc_addr[BANK_LSB +: BANK_W];
  assign row_in  = I_sdrc_addr[ROW_LSB +: ROW_W];
  assign col_in  = I_sdrc_addr[COL_LSB +: COL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      len_q     <= '0;
      autopre_q <= 1'b0;
      ack_q     <= 1'b0;
      rd_v_q    <= 1'b0;
      data_q    <= '0;
      open_q    <= '0;
      for (int b = 0; b < NUM_BANKS; b++) open_row_q[b] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      len_q      <= len_d;
      autopre_q  <= autopre_d;
      ack_q      <= ack_d;
      rd_v_q     <= rd_v_d;
      data_q     <= data_d;
      open_q     <= open_d;
      open_row_q <= open_row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    row_d      = row_q;
    col_d      = col_q;
    len_d      = len_q;
    autopre_d  = autopre_q;
    ack_d      = 1'b0;
    rd_v_d     = rd_issue;
    data_d     = rd_v_q ? ram_rdata : data_q;
    open_d     = open_q;
    open_row_d = open_row_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == CntW'(InitCycles - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_IDLE: begin
        if (sample && cmd != CMD_NOP) begin
          ack_d = 1'b1;
          case (cmd)
            CMD_LOAD_MODE, CMD_REFRESH, CMD_PRECHARGE, CMD_ACTIVATE: begin
              if (cmd == CMD_PRECHARGE) begin
                if (I_sdrc_addr[PRECHARGE_ALL_BIT]) open_d = '0;
                else open_d[bank_in] = 1'b0;
              end
              if (cmd == CMD_ACTIVATE) begin
                open_d[bank_in]     = 1'b1;
                open_row_d[bank_in] = row_in;
              end
              state_d = (CommandCycles > 1) ? ST_BUSY : ST_IDLE;
              cnt_d   = (CommandCycles > 1) ? CntW'(1) : '0;
            end
            CMD_WRITE, CMD_READ: begin
              bank_d    = bank_in;
              row_d     = open_row_q[bank_in];
              col_d     = col_in;
              len_d     = I_sdrc_data_len;
              autopre_d = I_sdrc_precharge_ctrl;
              cnt_d     = CntW'(1);
              if (cmd == CMD_READ) begin
                state_d = ST_READ_WAIT;
              end else if (I_sdrc_data_len != 8'd0) begin
                state_d = ST_WRITE;
              end else begin
                // Single-word write completes in T0 itself.
                cnt_d = '0;
                if (I_sdrc_precharge_ctrl) open_d[bank_in] = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        if (cnt_q == CntW'(len_q)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (autopre_q) open_d[bank_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_READ_WAIT: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ReadLatency - 1)) state_d = ST_READ;
      end
      ST_READ: begin
        if (cnt_q == CntW'(ReadLatency) + CntW'(len_q)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (autopre_q) open_d[bank_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == CntW'(CommandCycles - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Read word k is addressed two cycles ahead of T(ReadLatency+k): one for the
  // RAM register, one for the output data register.
  always_comb begin
    ram_we    = '0;
    rd_issue  = 1'b0;
    rd_idx    = cnt_q - CntW'(ReadLatency - 2);
    flat_addr = sdrc_flat_addr(bank_q, row_q, col_q + cnt_q[COL_W-1:0]);
    case (state_q)
      ST_IDLE: begin
        if (sample && (cmd == CMD_WRITE || cmd == CMD_READ)) begin
          flat_addr = sdrc_flat_addr(bank_in, open_row_q[bank_in], col_in);
          if (cmd == CMD_WRITE) ram_we = ~I_sdrc_dqm;
          else rd_issue = (ReadLatency == 2);
        end
      end
      ST_WRITE: ram_we = ~I_sdrc_dqm;
      ST_READ_WAIT, ST_READ: begin
        rd_issue  = (cnt_q >= CntW'(ReadLatency - 2)) && (rd_idx <= CntW'(len_q));
        flat_addr = sdrc_flat_addr(bank_q, row_q, col_q + rd_idx[COL_W-1:0]);
      end
      default: ;
    endcase
  end

  assign ram_addr         = DepthBits'(flat_addr);
  assign O_sdrc_data      = data_q;
  assign O_sdrc_init_done = (state_q != ST_INIT);
  assign O_sdrc_cmd_ack   = ack_q;

  sdram_emulator_ram #(
    .DepthBits(DepthBits)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(I_sdrc_data),
    .rdata_o(ram_rdata)
  );

`ifdef SDRC_EMULATOR_CHECK_EN
  logic err_q;
  logic v_busy, v_init, v_closed, v_reopen, v_power, v_undef;

  always_comb begin
    v_busy   = I_sdrc_cmd_en && state_q != ST_IDLE && state_q != ST_INIT;
    v_init   = I_sdrc_cmd_en && state_q == ST_INIT;
    v_closed = sample && (cmd == CMD_WRITE || cmd == CMD_READ) && !open_q[bank_in];
    v_reopen = sample && cmd == CMD_ACTIVATE && open_q[bank_in];
    v_power  = state_q != ST_INIT && (I_sdram_power_down || I_sdram_selfrefresh);
    v_undef  = sample && I_sdrc_cmd == 3'b110;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_q | v_busy | v_init | v_closed | v_reopen | v_power | v_undef;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (v_busy)   $error("sdrc emulator: cmd_en while not idle");
      if (v_init)   $error("sdrc emulator: cmd_en before init_done");
      if (v_closed) $error("sdrc emulator: read/write to bank %0d with no open row", bank_in);
      if (v_reopen) $error("sdrc emulator: activate to already-open bank %0d", bank_in);
      if (v_power)  $error("sdrc emulator: power_down/selfrefresh asserted");
      if (v_undef)  $error("sdrc emulator: undefined command code");
    end
  end
`endif

  assign protocol_error = err_q;
`else
  logic unused_pins;
  assign unused_pins    = I_sdram_power_down ^ I_sdram_selfrefresh;
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_controller_emulator.sv
// tb/tb_sdram_controller_emulator.sv - directed bench for sdram_controller_emulator
module tb_sdram_controller_emulator;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_NOP = 3'b111;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_en = 1'b0;
  logic [2:0]  cmd = 3'b111;
  logic        prech = 1'b0;
  logic        pd = 1'b0;
  logic        sr = 1'b0;
  logic [20:0] addr = '0;
  logic [3:0]  dqm = '0;
  logic [31:0] din = '0;
  logic [7:0]  dlen = '0;
  logic [31:0] dout;
  logic        init_done;
  logic        ack;
  logic        perr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] wbuf [8];
  logic [31:0] expd [8];
  int n_init;
  logic ack_seen;
  logic perr_exp;

  always #5 clk = ~clk;

  sdram_controller_emulator dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .I_sdrc_cmd_en        (cmd_en),
    .I_sdrc_cmd           (cmd),
    .I_sdrc_precharge_ctrl(prech),
    .I_sdram_power_down   (pd),
    .I_sdram_selfrefresh  (sr),
    .I_sdrc_addr          (addr),
    .I_sdrc_dqm           (dqm),
    .I_sdrc_data          (din),
    .I_sdrc_data_len      (dlen),
    .O_sdrc_data          (dout),
    .O_sdrc_init_done     (init_done),
    .O_sdrc_cmd_ack       (ack),
    .protocol_error       (perr)
  );

  function automatic logic [20:0] mk(input logic [1:0] b, input logic [10:0] r, input logic [7:0] c);
    return {b, r, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_init(output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (ack) seen = 1'b1;
      if (init_done) break;
    end
    @(negedge clk);
  endtask

  task automatic busy_cmd(input logic [2:0] c, input logic [20:0] a, input string tag);
    cmd_en = 1'b1; cmd = c; addr = a;
    @(negedge clk);
    chk(tag, ack, 1);
    cmd_en = 1'b0; cmd = C_NOP;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_burst(input logic [20:0] a, input int len, input logic [3:0] mask,
                             input logic pre, input string tag);
    cmd_en = 1'b1; cmd = C_WR; addr = a; dlen = 8'(len); prech = pre;
    din = wbuf[0]; dqm = mask;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk(tag, ack, 1);
        cmd_en = 1'b0; cmd = C_NOP; prech = 1'b0;
      end
      if (k <= len) din = wbuf[k];
    end
    dqm = '0;
  endtask

  task automatic read_burst(input logic [20:0] a, input int len, input logic pre,
                            input string tag, input logic check);
    cmd_en = 1'b1; cmd = C_RD; addr = a; dlen = 8'(len); prech = pre;
    for (int t = 1; t <= RL + len + 1; t++) begin
      @(negedge clk);
      if (t == 1) begin
        chk({tag, "_ack"}, ack, 1);
        cmd_en = 1'b0; cmd = C_NOP; prech = 1'b0;
      end
      if (t == 2) chk({tag, "_ack_drop"}, ack, 0);
      if (check && t >= RL && t <= RL + len)
        chk($sformatf("%s[%0d]", tag, t - RL), dout, expd[t-RL]);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", dout, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ack", ack, 0);
    chk("rst_perr", perr, 0);

    rst_n = 1'b1;
    wait_init(n_init, ack_seen);
    chk("init_cycles", n_init, 200);
    chk("init_ack_quiet", ack_seen, 0);

    busy_cmd(C_ACT, mk(2'd1, 11'd5, 8'd0), "act_b1r5_ack");
    for (int k = 0; k < 4; k++) wbuf[k] = 32'h11111111 * (k + 1);
    write_burst(mk(2'd1, 11'd5, 8'd0), 3, 4'b0000, 1'b0, "wr_c0_ack");
    for (int k = 0; k < 4; k++) expd[k] = 32'h11111111 * (k + 1);
    read_burst(mk(2'd1, 11'd5, 8'd0), 3, 1'b0, "rd_c0", 1'b1);

    for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE0000 + k;
    write_burst(mk(2'd1, 11'd5, 8'd254), 3, 4'b0000, 1'b0, "wr_wrap_ack");
    for (int k = 0; k < 4; k++) expd[k] = 32'hC0DE0000 + k;
    read_burst(mk(2'd1, 11'd5, 8'd254), 3, 1'b0, "rd_wrap", 1'b1);
    expd[0] = 32'hC0DE0002; expd[1] = 32'hC0DE0003; expd[2] = 32'h33333333;
    read_burst(mk(2'd1, 11'd5, 8'd0), 2, 1'b0, "rd_wrap_c0", 1'b1);

    wbuf[0] = 32'h00000000;
    write_burst(mk(2'd1, 11'd5, 8'd16), 0, 4'b0000, 1'b0, "wr_zero_ack");
    wbuf[0] = 32'hAABBCCDD;
    write_burst(mk(2'd1, 11'd5, 8'd16), 0, 4'b0101, 1'b0, "wr_mask_ack");
    expd[0] = 32'hAA00CC00;
    read_burst(mk(2'd1, 11'd5, 8'd16), 0, 1'b0, "rd_mask", 1'b1);
    chk("perr_clean", perr, 0);

    expd[0] = 32'hC0DE0002; expd[1] = 32'hC0DE0003;
    read_burst(mk(2'd1, 11'd5, 8'd0), 1, 1'b1, "rd_autopre", 1'b1);
    chk("perr_after_autopre", perr, 0);
    read_burst(mk(2'd1, 11'd5, 8'd0), 0, 1'b0, "rd_closed", 1'b0);
`ifdef SDRC_EMULATOR_CHECK_EN
    perr_exp = 1'b1;
`else
    perr_exp = 1'b0;
`endif
    chk("perr_closed_bank", perr, perr_exp);

    busy_cmd(C_ACT, mk(2'd2, 11'd9, 8'd0), "act_b2r9_ack");
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h50000000 + k;
    write_burst(mk(2'd2, 11'd9, 8'd32), 7, 4'b0000, 1'b0, "wr_base_ack");

    for (int k = 0; k < 8; k++) wbuf[k] = 32'h60000000 + k;
    cmd_en = 1'b1; cmd = C_WR; addr = mk(2'd2, 11'd9, 8'd32); dlen = 8'd7;
    din = wbuf[0]; dqm = 4'b0000;
    @(negedge clk);
    cmd_en = 1'b0; cmd = C_NOP; din = wbuf[1];
    @(negedge clk);
    din = wbuf[2];
    rst_n = 1'b0;
    #1;
    chk("abort_data", dout, 0);
    chk("abort_init_done", init_done, 0);
    chk("abort_ack", ack, 0);
    chk("abort_perr", perr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n_init, ack_seen);
    chk("reinit_cycles", n_init, 200);

    busy_cmd(C_ACT, mk(2'd2, 11'd9, 8'd0), "react_b2r9_ack");
    expd[0] = 32'h60000000; expd[1] = 32'h60000001;
    for (int k = 2; k < 8; k++) expd[k] = 32'h50000000 + k;
    read_burst(mk(2'd2, 11'd9, 8'd32), 7, 1'b0, "rd_abort", 1'b1);
    chk("perr_final", perr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_controller_emulator.md
# sdram_controller_emulator

Cycle-level stand-in for the vendor SDRAM controller's user-side command interface, backed by on-chip block RAM. It sits where the SDRAM controller sits: the ramio/cache side issues commands to it exactly as it would to the real controller. This lets simulation and SDRAM-less builds run the full core and cache path. It responds to the cache's command handshake, emulates row open/close per bank, and performs page bursts with byte masks.

## Interface
- `DepthBits`, 15: log2 of 32-bit words of backing RAM; memory index is the low `DepthBits` bits of {bank, row, col}.
- `InitCycles`, 200: cycles after reset before `O_sdrc_init_done` rises.
- `ReadLatency`, 4: cycles from command sample (T0) to first read word.
- `CommandCycles`, 3: busy cycles for activate, precharge, refresh and load-mode.
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `I_sdrc_cmd_en` in 1: command strobe.
- `I_sdrc_cmd` in 3: command code.
- `I_sdrc_precharge_ctrl` in 1: auto-precharge (close row) after read/write.
- `I_sdram_power_down`, `I_sdram_selfrefresh` in 1 each: must stay 0.
- `I_sdrc_addr` in 21: [20:19] bank, [18:8] row, [7:0] column.
- `I_sdrc_dqm` in 4: byte mask, bit=1 masks the byte.
- `I_sdrc_data` in 32: write data.
- `I_sdrc_data_len` in 8: burst length minus 1.
- `O_sdrc_data` out 32: read data.
- `O_sdrc_init_done` out 1: initialisation complete.
- `O_sdrc_cmd_ack` out 1: one-cycle command acknowledge.
- `protocol_error` out 1: sticky misuse flag.

## Operation
- States: INIT, IDLE, WRITE, READ_WAIT, READ, BUSY.
- INIT: counts `InitCycles`, then raises `init_done` and enters IDLE. All rows start closed.
- Commands are sampled only in IDLE with `cmd_en`=1. The sample cycle is T0. Any `cmd_en` outside IDLE is ignored.
- Command encodings:
  - NOP 3'b111: no ack, no state change.
  - LOAD_MODE 3'b000, REFRESH 3'b001: BUSY.
  - PRECHARGE 3'b010: closes the bank in addr[20:19], or all banks if addr[10]=1, then BUSY.
  - ACTIVATE 3'b011: latches the row into `open_row[bank]`, marks it open, then BUSY.
  - WRITE 3'b100, READ 3'b101: burst of `data_len`+1 words at {bank, open_row[bank], col}.
- Burst column increments mod 256 and wraps within the row. Bank and row are fixed for the burst.
- Write: word k is captured at the end of Tk. Byte b is written only when dqm[b]=0. `dqm` is sampled per word.
- If `precharge_ctrl`=1 at T0, the bank is closed after the burst's last word.
- Undefined code 3'b110: acked, treated as NOP.
- Memory is not cleared by reset.

## Timing
- Reset values: `O_sdrc_data`=0, `init_done`=0, `cmd_ack`=0, `protocol_error`=0, state INIT.
- `cmd_ack` is high during T1 only, for every command except NOP.
- Write: IDLE again at T(len+1), where the next command may be sampled.
- Read: word k drives `O_sdrc_data` during T(`ReadLatency`+k). Next sample at T(`ReadLatency`+len+1). `O_sdrc_data` holds its last value between bursts.
- BUSY commands: next sample at T(`CommandCycles`).
- Asynchronous reset mid-operation aborts the burst, re-enters INIT and drops `init_done`. Words already written stay written.
- `ReadLatency` ≥ 2 is required; lower values are a parameter error (elaboration assertion).

## Configuration
- `SDRC_EMULATOR_CHECK_EN` defined: `protocol_error` sets and stays set on any of:
  - `cmd_en` outside IDLE.
  - `cmd_en` before `init_done`.
  - READ/WRITE to a bank with no open row.
  - ACTIVATE to an already-open bank.
  - `power_down` or `selfrefresh` high after INIT.
  - Undefined command code.
- Each violation also emits a `$error` in simulation only.
- Not defined: `protocol_error` is tied 0 and no checker logic is built.

## Structure
- Package `sdram_pkg` holds:
  - The command enum (the seven codes above).
  - Address field widths and positions (bank 2, row 11, column 8).
  - The `SDRAM_BURST_MAX` constant 256.
- One sub-module, `sdram_emulator_ram`: single-port 32-bit RAM with 4 byte-write enables and registered read, `2**DepthBits` deep. Its one-cycle read latency is absorbed inside `ReadLatency`.

## Test plan
- Reset; cycle count until `init_done` → exactly 200 cycles, `cmd_ack` 0 throughout.
- ACTIVATE bank 1 row 5; WRITE col 0, len 3, data 0x11111111..0x44444444, dqm 0 → ack at T1 of each command. READ col 0 len 3 → same four words at T4..T7.
- WRITE col 254, len 3 → words land at cols 254, 255, 0, 1 of the same row. Read back confirms.
- WRITE 0xAABBCCDD over 0x00000000 with dqm 4'b0101 → read returns 0xAA00CC00.
- READ with `precharge_ctrl`=1, then READ again without ACTIVATE → `protocol_error`=1 under the macro, 0 without it.
- Assert `rst_n`=0 mid-burst at T2 of a len-7 write → outputs reset immediately; after re-init, words 0..1 are present and words 2..7 unchanged.
